// File: rtl/gencon_wide_pkg.sv
// Shared types and helpers for the parametrised signed calculator controller.
package gencon_wide_pkg;

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        OP_WAIT = 3'd1,
        COMPUTE = 3'd2,
        ENTRY_B = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;

    // Largest positive value representable in width signed bits.
    function automatic logic [63:0] max_pos(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Magnitude of the most negative value representable in width signed bits.
    function automatic logic [63:0] min_neg(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic logic is_op(input logic [2:0] code);
        return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL);
    endfunction

endpackage

// File: rtl/gencon_wide_seq_mult.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle; done pulses
// for one cycle alongside the final product.
module seq_mult #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [PW-1:0]    prod_q, prod_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start) begin
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CW'(WIDTH);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: rtl/gencon_wide.sv
// Signed keypad calculator controller: operand entry with range checking,
// add/sub/multiply, overflow flag with saturate or wrap.
module gencon_wide
    import gencon_wide_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter bit          SAT_MODE   = 1'b0,
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [3:0]       keypad_input,
    input  logic             read_input,
    input  logic [2:0]       operator_input,
    input  logic             equal_input,
    input  logic             clear_input,
    output logic             complete,
    output logic             overflow,
    output logic [WIDTH-1:0] display_output,
    output logic [2:0]       tb_current_state
);

    localparam int unsigned MW   = WIDTH + 4;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CNTW = $clog2(MAX_DIGITS + 1);

    localparam logic [MW-1:0]    LIM_POS  = MW'(max_pos(WIDTH));
    localparam logic [MW-1:0]    LIM_NEG  = MW'(min_neg(WIDTH));
    localparam logic [PW-1:0]    PLIM_POS = PW'(max_pos(WIDTH));
    localparam logic [PW-1:0]    PLIM_NEG = PW'(min_neg(WIDTH));
    localparam logic [WIDTH-1:0] SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [CNTW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              fin_q, fin_d;

    logic [WIDTH-1:0]  cur_mag;
    logic              cur_sign;
    logic [CNTW-1:0]   cur_cnt;
    logic [MW-1:0]     mag_next;
    logic              digit_ok;
    logic              restart;

    logic [WIDTH-1:0]  sval_a, sval_b;
    logic [WIDTH:0]    sum;
    logic              ovf_as;
    logic [WIDTH-1:0]  res_as;

    logic              mul_start, mul_done, mul_rst_n, mul_neg, ovf_m;
    logic [PW-1:0]     product;
    logic [WIDTH-1:0]  res_m, wrap_m;

    assign mul_rst_n = nRST & ~clear_input;

    seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .nRST    (mul_rst_n),
        .start   (mul_start),
        .a       (mag_a_q),
        .b       (mag_b_q),
        .done    (mul_done),
        .product (product)
    );

    // In DONE the operand under entry is a fresh, empty A.
    always_comb begin
        cur_mag  = mag_a_q;
        cur_sign = sign_a_q;
        cur_cnt  = cnt_a_q;
        if (state_q == ENTRY_B) begin
            cur_mag  = mag_b_q;
            cur_sign = sign_b_q;
            cur_cnt  = cnt_b_q;
        end else if (state_q == DONE) begin
            cur_mag  = '0;
            cur_sign = 1'b0;
            cur_cnt  = '0;
        end
        mag_next = {4'b0000, cur_mag} * MW'(10) + {{WIDTH{1'b0}}, keypad_input};
        digit_ok = (keypad_input <= 4'd9) && (cur_cnt < CNTW'(MAX_DIGITS)) &&
                   (mag_next <= (cur_sign ? LIM_NEG : LIM_POS));
    end

    always_comb begin
        sval_a = sign_a_q ? -mag_a_q : mag_a_q;
        sval_b = sign_b_q ? -mag_b_q : mag_b_q;
        if (op_q == OP_SUB) begin
            sum = {sval_a[WIDTH-1], sval_a} - {sval_b[WIDTH-1], sval_b};
        end else begin
            sum = {sval_a[WIDTH-1], sval_a} + {sval_b[WIDTH-1], sval_b};
        end
        ovf_as = sum[WIDTH] ^ sum[WIDTH-1];
        res_as = sum[WIDTH-1:0];
        if (ovf_as && SAT_MODE) begin
            res_as = sum[WIDTH] ? SAT_NEG : SAT_POS;
        end

        mul_neg = (sign_a_q ^ sign_b_q) && (product != '0);
        ovf_m   = product > (mul_neg ? PLIM_NEG : PLIM_POS);
        wrap_m  = mul_neg ? -product[WIDTH-1:0] : product[WIDTH-1:0];
        res_m   = wrap_m;
        if (ovf_m && SAT_MODE) begin
            res_m = mul_neg ? SAT_NEG : SAT_POS;
        end
    end

    always_comb begin
        state_d   = state_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        op_d      = op_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        fin_d     = fin_q;
        mul_start = 1'b0;

        // A digit in DONE wipes everything first; the DONE branch then loads it into A.
        restart = (state_q == DONE) && read_input && (keypad_input <= 4'd9);
        if (clear_input || restart) begin
            state_d  = ENTRY_A;
            mag_a_d  = '0;
            mag_b_d  = '0;
            sign_a_d = 1'b0;
            sign_b_d = 1'b0;
            cnt_a_d  = '0;
            cnt_b_d  = '0;
            op_d     = '0;
            result_d = '0;
            ovf_d    = 1'b0;
            fin_d    = 1'b0;
        end

        if (!clear_input) begin
            unique case (state_q)
                ENTRY_A, ENTRY_B: begin
                    if (read_input) begin
                        if (digit_ok) begin
                            if (state_q == ENTRY_B) begin
                                mag_b_d = mag_next[WIDTH-1:0];
                                cnt_b_d = cnt_b_q + CNTW'(1);
                            end else begin
                                mag_a_d = mag_next[WIDTH-1:0];
                                cnt_a_d = cnt_a_q + CNTW'(1);
                            end
                        end
                    end else if (operator_input != 3'b000) begin
                        if (operator_input == OP_ADD && cur_cnt == '0) begin
                            if (state_q == ENTRY_B) sign_b_d = ~sign_b_q;
                            else                    sign_a_d = ~sign_a_q;
                        end else if (state_q == ENTRY_A && is_op(operator_input) &&
                                     cnt_a_q != '0) begin
                            op_d    = operator_input;
                            state_d = OP_WAIT;
                        end
                    end else if (equal_input && state_q == ENTRY_B && cnt_b_q != '0) begin
                        state_d = COMPUTE;
                        fin_d   = 1'b0;
                    end
                end
                OP_WAIT: begin
                    if (operator_input == 3'b000) state_d = ENTRY_B;
                end
                COMPUTE: begin
                    if (op_q == OP_MUL) begin
                        if (!fin_q) begin
                            mul_start = 1'b1;
                            fin_d     = 1'b1;
                        end else if (mul_done) begin
                            result_d = res_m;
                            ovf_d    = ovf_m;
                            state_d  = DONE;
                        end
                    end else if (!fin_q) begin
                        result_d = res_as;
                        ovf_d    = ovf_as;
                        fin_d    = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (restart && digit_ok) begin
                        mag_a_d = mag_next[WIDTH-1:0];
                        cnt_a_d = CNTW'(1);
                    end
                end
                default: state_d = ENTRY_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q  <= ENTRY_A;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            op_q     <= op_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            fin_q    <= fin_d;
        end
    end

    always_comb begin
        unique case (state_q)
            ENTRY_A:                   display_output = sval_a;
            OP_WAIT, ENTRY_B, COMPUTE: display_output = sval_b;
            DONE:                      display_output = result_q;
            default:                   display_output = '0;
        endcase
    end

    assign complete         = (state_q == DONE);
    assign overflow         = (state_q == DONE) & ovf_q;
    assign tb_current_state = state_q;

endmodule

// File: doc/gencon_wide.md
Name: gencon_wide

Overview:
Parametrised successor to the 16-bit signed calculator controller.
- Accepts decimal keypad digits, a sign toggle, one-hot operator selection and an equal press.
- Computes add, subtract or multiply on WIDTH-bit two's-complement operands.
- Adds a sequential shift-add multiplier, an overflow flag, selectable saturate/wrap, and operand range checking during entry.
- Sits between keypad/button debouncers and the display driver.

Parameters:
WIDTH, 16, operand/result width in bits (4..32), two's complement
SAT_MODE, 0, 1 = saturate result on overflow; 0 = wrap to low WIDTH bits
MAX_DIGITS, 5, max decimal digits accepted per operand; extra digits ignored

Ports:
clk  in  1  rising-edge clock
nRST  in  1  synchronous active-low reset
keypad_input  in  4  BCD digit; values >9 ignored
read_input  in  1  one-cycle strobe: sample keypad_input
operator_input  in  3  one-hot: 001 add/negate, 010 subtract, 100 multiply
equal_input  in  1  level; request computation
clear_input  in  1  synchronous clear to entry of operand A
complete  out  1  high while result valid (DONE state)
overflow  out  1  result not representable in WIDTH signed bits; valid with complete
display_output  out  WIDTH  current operand during entry, result in DONE
tb_current_state  out  3  state_t encoding, for benches

Behaviour:
- Reset (nRST=0 at posedge): state ENTRY_A; operands, sign flags, digit counts, op, result = 0; complete=0, overflow=0, display_output=0. Reset in any state, including mid-multiply, aborts the operation.
- Priority within one cycle: nRST > clear_input > read_input > operator_input > equal_input.
- clear_input: same effect as reset, but not applied while nRST=0.
- States (state_t): ENTRY_A=0, OP_WAIT=1, COMPUTE=2, ENTRY_B=3, DONE=4.
- Digit accept (ENTRY_A/ENTRY_B, read_input=1, keypad_input<=9, count<MAX_DIGITS):
  - mag_next = mag*10 + digit, computed in WIDTH+4 bits.
  - Accepted only if mag_next <= 2^(WIDTH-1)-1 (sign positive) or <= 2^(WIDTH-1) (sign negative); otherwise the register and count are unchanged.
- Sign: operator_input=001 while the current operand's digit count = 0 toggles its sign flag. No other effect.
- ENTRY_A: a one-hot operator with count_A > 0 latches op and moves to OP_WAIT. Multi-hot or zero operator codes are ignored.
- OP_WAIT: moves to ENTRY_B once operator_input==0. This prevents a held button from negating B.
- ENTRY_B: equal_input=1 with count_B > 0 moves to COMPUTE. Equal with count_B = 0 is ignored.
- COMPUTE, add/sub: exact sum/difference in WIDTH+1 bits, registered in one cycle.
  - complete rises on the 2nd posedge after the edge that sampled equal_input.
- COMPUTE, multiply: shift-add over magnitudes, one bit per cycle, WIDTH cycles, 2*WIDTH-bit product, then sign = sA XOR sB.
  - complete rises on edge WIDTH+2 after the edge that sampled equal_input.
- Overflow: the exact result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - SAT_MODE=1: clamp to 0x7F..F or 0x80..0.
  - SAT_MODE=0: low WIDTH bits.
- display_output:
  - ENTRY_A: signed A.
  - OP_WAIT/ENTRY_B: signed B, which is 0 until the first B digit.
  - COMPUTE: holds the previous value.
  - DONE: result.
- DONE: complete and result are held. A valid read_input clears all state and enters ENTRY_A, with that digit accepted as A's first digit. operator_input and equal_input are ignored.

Decomposition:
- Package gencon_wide_pkg: state_t; op codes OP_ADD=3'b001, OP_SUB=3'b010, OP_MUL=3'b100; function max_pos(WIDTH); function min_neg(WIDTH).
- Sub-module seq_mult (parametrised WIDTH): start/done handshake, unsigned magnitude shift-add, synchronous nRST.

Test Plan:
- WIDTH=16, SAT=0: 2 + 3, equal -> complete on 2nd edge after equal; display 0x0005; overflow 0.
- WIDTH=16: -32768 + 32767 -> 0xFFFF, overflow 0; -12 * 3000 -> SAT=0 0x7360, overflow 1; SAT=1 0x8000, overflow 1.
- WIDTH=16, SAT=1: 128 * 256 -> 0x7FFF, overflow 1; complete exactly 18 edges after equal sampled.
- WIDTH=16: digits 9,9,9,9,9 on positive A -> 5th rejected, display 0x270F; sign toggle then 3,2,7,6,8 -> 0x8000 accepted.
- WIDTH=8: 100 + 100 -> SAT=1 0x7F, SAT=0 0xC8, overflow 1 both; -3 - -5 -> 0x02.
- Start 7 * 9, drop nRST at 5th COMPUTE cycle -> next edge ENTRY_A, display 0, complete 0. Digit press in DONE -> new A equals that digit.
